pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write-enable and flush/bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three conditions: load-use hazards, taken-branch flushes and multi-cycle data-memory waits (with timeout).
- Keeps saturating performance counters; sits beside the datapath in the top-level CPU.

Parameters:
- REG_ADDR_W, 5, register-file index width
- CNT_W, 16, width of each performance counter
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before error (must be >= 2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_rs  in  REG_ADDR_W  source register 1 of the instruction in ID
- id_rt  in  REG_ADDR_W  source register 2 of the instruction in ID
- id_uses_rs  in  1  ID instruction reads id_rs
- id_uses_rt  in  1  ID instruction reads id_rt
- ex_valid  in  1  EX stage holds a real instruction
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  REG_ADDR_W  EX destination register
- branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  MEM stage issues a data-memory access this cycle
- mem_ready  in  1  data memory completes access this cycle
- pc_write_en  out  1  PC may update
- if_id_write_en  out  1  IF/ID may load
- if_id_flush  out  1  IF/ID loads zero (NOP)
- id_ex_bubble  out  1  ID/EX loads zero (NOP)
- ex_mem_write_en  out  1  EX/MEM may load
- mem_wb_write_en  out  1  MEM/WB may load
- mem_timeout_err  out  1  sticky memory-timeout error
- stall_cycles  out  CNT_W  count of cycles with pc_write_en=0
- flush_count  out  CNT_W  count of branch flush cycles

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- While rst=0:
  - pc_write_en=0, if_id_write_en=0, ex_mem_write_en=0, mem_wb_write_en=0.
  - if_id_flush=1, id_ex_bubble=1.
  - mem_timeout_err=0, counters=0, wait counter=0.
- Control outputs are combinational from state and current inputs, giving zero-cycle latency. State and counters update on posedge clk.
- freeze = (RUN & mem_req & !mem_ready) | (MEM_WAIT & !mem_ready) | ERROR.
- Priority, per cycle, outside reset:
  - freeze: all four write enables 0, if_id_flush=0, id_ex_bubble=0. Every stage holds.
  - else branch_taken: all enables 1, if_id_flush=1, id_ex_bubble=1. Both wrong-path instructions are killed.
  - else load_use: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, ex_mem_write_en=1, mem_wb_write_en=1.
  - else: all enables 1, flushes 0.
- load_use = ex_valid & ex_mem_read & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Register 0 never causes a hazard.
- Transitions:
  - RUN -> MEM_WAIT when mem_req & !mem_ready; wait counter := 1.
  - MEM_WAIT -> RUN when mem_ready; same-cycle release, so all enables are 1 in that cycle per priority.
  - MEM_WAIT with !mem_ready: wait counter +1. When it reaches MEM_TIMEOUT -> ERROR and mem_timeout_err := 1.
  - ERROR is absorbing until rst; the pipeline stays frozen.
- mem_req is ignored in MEM_WAIT (the request is held by the frozen stage).
- branch_taken/load_use during freeze: no effect. They are re-evaluated when the freeze ends, because the frozen stages hold their inputs stable.
- Counters:
  - stall_cycles +1 every clocked cycle with rst=1 and pc_write_en=0.
  - flush_count +1 every cycle with if_id_flush=1 and rst=1.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-MEM_WAIT or in ERROR: immediate return to RUN with all values at reset.

Decomposition:
- Shared package: state enum type (RUN, MEM_WAIT, ERROR) and the reset polarity constant.
- Sub-module sat_counter(CNT_W): enable in, saturating count out, async active-low reset. Instantiated twice.

Test Plan:
- Load-use: ex_valid=1, ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 for 1 cycle -> pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 for exactly that cycle; stall_cycles 0->1.
- Zero register: same as load-use but ex_rd=0, id_rs=0 -> no stall, all enables 1, stall_cycles stays 0.
- Branch plus load-use in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1; flush_count=1, stall_cycles=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all enables 0 for 3 cycles, 1 on the 4th; state returns to RUN; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout_err=1 after 4 wait cycles; pipeline stays frozen; pulse rst=0 -> err=0, state RUN.
- Saturation: CNT_W=4, hold the load-use condition 20 cycles -> stall_cycles=15 and holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Ports: none. Provides the sequencer state enum and the reset polarity constant.
package pipeline_hazard_ctrl_pkg;

   // RUN: normal flow; MEM_WAIT: data memory outstanding; ERROR: memory timed out.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   // Level of rst that holds the block in reset.
   localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the datapath and the hazard controller.
// Latency: n/a (wires only).
// Ports: master = datapath (drives hazard inputs, sinks controls); slave = controller.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   // Hazard inputs from the datapath
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic                  id_uses_rs;
   logic                  id_uses_rt;
   logic                  ex_valid;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  branch_taken;
   logic                  mem_req;
   logic                  mem_ready;

   // Pipeline register controls
   logic                  pc_write_en;
   logic                  if_id_write_en;
   logic                  if_id_flush;
   logic                  id_ex_bubble;
   logic                  ex_mem_write_en;
   logic                  mem_wb_write_en;

   // Status
   logic                  mem_timeout_err;
   logic [CNT_W-1:0]      stall_cycles;
   logic [CNT_W-1:0]      flush_count;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_valid, ex_mem_read, ex_rd,
             branch_taken, mem_req, mem_ready,
      input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
             ex_mem_write_en, mem_wb_write_en, mem_timeout_err, stall_cycles, flush_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_valid, ex_mem_read, ex_rd,
             branch_taken, mem_req, mem_ready,
      output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
             ex_mem_write_en, mem_wb_write_en, mem_timeout_err, stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments when en=1, sticks at all-ones.
// Latency: one cycle from en to count.
// Ports: clk, rst (async active-low), en in; count out (CNT_W bits).
module sat_counter
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + CNT_ONE;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, memory wait/timeout.
// Latency: controls are combinational from state + inputs (zero cycle); state/counters on posedge.
// Ports: clk, rst (async active-low); bus (slave) carries hazard inputs, stage controls, error, counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   pipeline_hazard_ctrl_if.slave  bus
);

   localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
   localparam logic [WAIT_W-1:0] TIMEOUT_V = MEM_TIMEOUT[WAIT_W-1:0];

   state_t              state;
   state_t              state_nxt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [WAIT_W-1:0]   wait_nxt;

   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  load_use;
   logic                  freeze;

   assign id_rs = bus.id_rs;
   assign id_rt = bus.id_rt;
   assign ex_rd = bus.ex_rd;

   // Register 0 is hardwired to zero, so a load into it never creates a dependency.
   assign load_use = bus.ex_valid && bus.ex_mem_read && (ex_rd != '0) &&
                     ((bus.id_uses_rs && (id_rs == ex_rd)) ||
                      (bus.id_uses_rt && (id_rt == ex_rd)));

   // mem_req only matters in RUN; in MEM_WAIT the frozen MEM stage still holds it.
   always_comb begin
      freeze = 1'b1;
      unique case (state)
         RUN:      freeze = bus.mem_req && !bus.mem_ready;
         MEM_WAIT: freeze = !bus.mem_ready;
         ERROR:    freeze = 1'b1;
         default:  freeze = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Next-state logic; wait_cnt counts cycles spent frozen on the current access,
   // including the RUN cycle that first saw the miss.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      unique case (state)
         RUN: begin
            if (bus.mem_req && !bus.mem_ready) begin
               state_nxt = MEM_WAIT;
               wait_nxt  = WAIT_ONE;
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ready) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end else begin
               wait_nxt = wait_cnt + WAIT_ONE;
               if (wait_nxt == TIMEOUT_V) begin
                  state_nxt = ERROR;
               end
            end
         end
         ERROR: begin
            state_nxt = ERROR;
         end
         default: begin
            state_nxt = RUN;
            wait_nxt  = '0;
         end
      endcase
   end

   // Output logic. Freeze wins over everything: a frozen stage keeps its inputs stable,
   // so branch/load-use are simply re-evaluated once the freeze lifts.
   always_comb begin
      bus.pc_write_en     = 1'b1;
      bus.if_id_write_en  = 1'b1;
      bus.if_id_flush     = 1'b0;
      bus.id_ex_bubble    = 1'b0;
      bus.ex_mem_write_en = 1'b1;
      bus.mem_wb_write_en = 1'b1;
      if (rst == RST_ACTIVE) begin
         bus.pc_write_en     = 1'b0;
         bus.if_id_write_en  = 1'b0;
         bus.if_id_flush     = 1'b1;
         bus.id_ex_bubble    = 1'b1;
         bus.ex_mem_write_en = 1'b0;
         bus.mem_wb_write_en = 1'b0;
      end else if (freeze) begin
         bus.pc_write_en     = 1'b0;
         bus.if_id_write_en  = 1'b0;
         bus.ex_mem_write_en = 1'b0;
         bus.mem_wb_write_en = 1'b0;
      end else if (bus.branch_taken) begin
         // Kill both wrong-path instructions (in IF and ID).
         bus.if_id_flush  = 1'b1;
         bus.id_ex_bubble = 1'b1;
      end else if (load_use) begin
         // Hold PC and IF/ID, insert one bubble into EX; older stages drain.
         bus.pc_write_en    = 1'b0;
         bus.if_id_write_en = 1'b0;
         bus.id_ex_bubble   = 1'b1;
      end
   end

   assign bus.mem_timeout_err = (state == ERROR);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (!bus.pc_write_en),
      .count (bus.stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (bus.if_id_flush),
      .count (bus.flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed cases plus randomized traffic,
// all checked every cycle against a behavioural model of the hazard rules.
// Ports: none (top-level bench).
module tb_pipeline_hazard_ctrl;
   import pipeline_hazard_ctrl_pkg::*;

   localparam int RW   = 5;
   localparam int CW   = 4;
   localparam int TO   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;

   pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

   pipeline_hazard_ctrl #(
      .REG_ADDR_W  (RW),
      .CNT_W       (CW),
      .MEM_TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model state: are we waiting on memory, for how many frozen cycles, errored, counters.
   bit m_wait;
   bit m_err;
   int m_wcnt;
   int m_stall;
   int m_flush;

   // Expected controls for the current cycle
   logic e_pc, e_ifw, e_iff, e_bub, e_exw, e_mww;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wait  = 1'b0;
      m_err   = 1'b0;
      m_wcnt  = 0;
      m_stall = 0;
      m_flush = 0;
   endtask

   task automatic model_eval();
      bit hit;
      bit frz;
      if (!rst) begin
         model_reset();
         {e_pc, e_ifw, e_exw, e_mww} = 4'b0000;
         {e_iff, e_bub} = 2'b11;
      end else begin
         hit = bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != 0) &&
               ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
                (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
         if (m_err)       frz = 1'b1;
         else if (m_wait) frz = !bus.mem_ready;
         else             frz = bus.mem_req && !bus.mem_ready;
         if (frz) begin
            {e_pc, e_ifw, e_exw, e_mww, e_iff, e_bub} = 6'b0000_00;
         end else if (bus.branch_taken) begin
            {e_pc, e_ifw, e_exw, e_mww, e_iff, e_bub} = 6'b1111_11;
         end else if (hit) begin
            {e_pc, e_ifw, e_exw, e_mww, e_iff, e_bub} = 6'b0011_01;
         end else begin
            {e_pc, e_ifw, e_exw, e_mww, e_iff, e_bub} = 6'b1111_00;
         end
      end
   endtask

   // Clock-edge update, using the expected controls of the cycle just ending.
   task automatic model_update();
      if (!rst) begin
         model_reset();
      end else begin
         if (!e_pc) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
         if (e_iff) m_flush = (m_flush + 1 > CMAX) ? CMAX : m_flush + 1;
         if (m_err) begin
            // absorbing
         end else if (m_wait) begin
            if (bus.mem_ready) begin
               m_wait = 1'b0;
               m_wcnt = 0;
            end else begin
               m_wcnt++;
               if (m_wcnt >= TO) begin
                  m_err  = 1'b1;
                  m_wait = 1'b0;
               end
            end
         end else if (bus.mem_req && !bus.mem_ready) begin
            m_wait = 1'b1;
            m_wcnt = 1;
         end
      end
   endtask

   task automatic compare();
      model_eval();
      chk("pc_write_en",     bus.pc_write_en,     e_pc);
      chk("if_id_write_en",  bus.if_id_write_en,  e_ifw);
      chk("if_id_flush",     bus.if_id_flush,     e_iff);
      chk("id_ex_bubble",    bus.id_ex_bubble,    e_bub);
      chk("ex_mem_write_en", bus.ex_mem_write_en, e_exw);
      chk("mem_wb_write_en", bus.mem_wb_write_en, e_mww);
      chk("mem_timeout_err", bus.mem_timeout_err, m_err);
      chk("stall_cycles",    bus.stall_cycles,    m_stall);
      chk("flush_count",     bus.flush_count,     m_flush);
   endtask

   // Inputs are driven just after posedge; compare just after negedge; model steps at posedge.
   task automatic cycle();
      @(negedge clk);
      #1;
      compare();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      bus.id_rs        = '0;
      bus.id_rt        = '0;
      bus.id_uses_rs   = 1'b0;
      bus.id_uses_rt   = 1'b0;
      bus.ex_valid     = 1'b0;
      bus.ex_mem_read  = 1'b0;
      bus.ex_rd        = '0;
      bus.branch_taken = 1'b0;
      bus.mem_req      = 1'b0;
      bus.mem_ready    = 1'b1;
   endtask

   task automatic load_use_in(input logic [RW-1:0] r);
      bus.ex_valid    = 1'b1;
      bus.ex_mem_read = 1'b1;
      bus.ex_rd       = r;
      bus.id_rs       = r;
      bus.id_uses_rs  = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle();
      cycle();
      rst = 1'b1;
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      idle();
      rst = 1'b0;
      cycle();
      chk("reset_pc_write_en", bus.pc_write_en, 0);
      chk("reset_if_id_flush", bus.if_id_flush, 1);
      chk("reset_id_ex_bubble", bus.id_ex_bubble, 1);
      chk("reset_stall_cycles", bus.stall_cycles, 0);
      rst = 1'b1;
      #1;

      // Load-use for exactly one cycle
      load_use_in(5'd5);
      #1;
      chk("lu_pc_write_en", bus.pc_write_en, 0);
      chk("lu_if_id_write_en", bus.if_id_write_en, 0);
      chk("lu_id_ex_bubble", bus.id_ex_bubble, 1);
      chk("lu_ex_mem_write_en", bus.ex_mem_write_en, 1);
      cycle();
      chk("lu_stall_cycles", bus.stall_cycles, 1);
      idle();
      #1;
      chk("lu_release_pc", bus.pc_write_en, 1);
      cycle();

      // Register zero never hazards
      do_reset();
      load_use_in(5'd0);
      #1;
      chk("r0_pc_write_en", bus.pc_write_en, 1);
      chk("r0_id_ex_bubble", bus.id_ex_bubble, 0);
      cycle();
      chk("r0_stall_cycles", bus.stall_cycles, 0);

      // Branch beats load-use
      do_reset();
      load_use_in(5'd7);
      bus.branch_taken = 1'b1;
      #1;
      chk("br_if_id_flush", bus.if_id_flush, 1);
      chk("br_id_ex_bubble", bus.id_ex_bubble, 1);
      chk("br_pc_write_en", bus.pc_write_en, 1);
      cycle();
      chk("br_flush_count", bus.flush_count, 1);
      chk("br_stall_cycles", bus.stall_cycles, 0);

      // Memory wait: 3 frozen cycles then release
      do_reset();
      bus.mem_req   = 1'b1;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("mw_pc_frozen", bus.pc_write_en, 0);
         chk("mw_mem_wb_frozen", bus.mem_wb_write_en, 0);
         cycle();
      end
      bus.mem_ready = 1'b1;
      #1;
      chk("mw_release_pc", bus.pc_write_en, 1);
      chk("mw_release_mem_wb", bus.mem_wb_write_en, 1);
      cycle();
      chk("mw_stall_cycles", bus.stall_cycles, 3);
      bus.mem_req   = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      chk("mw_back_in_run", bus.pc_write_en, 1);
      cycle();

      // Timeout into ERROR, then reset recovery
      do_reset();
      bus.mem_req   = 1'b1;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      chk("to_err_not_yet", bus.mem_timeout_err, 0);
      cycle();
      chk("to_err_set", bus.mem_timeout_err, 1);
      bus.mem_req   = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      chk("to_stays_frozen", bus.pc_write_en, 0);
      cycle();
      chk("to_err_sticky", bus.mem_timeout_err, 1);
      rst = 1'b0;
      #1;
      chk("to_err_cleared", bus.mem_timeout_err, 0);
      cycle();
      rst = 1'b1;
      idle();
      #1;
      chk("to_run_after_reset", bus.pc_write_en, 1);
      cycle();

      // Counter saturation
      do_reset();
      load_use_in(5'd3);
      for (int i = 0; i < 20; i++) cycle();
      chk("sat_stall_cycles", bus.stall_cycles, 15);
      cycle();
      chk("sat_stall_holds", bus.stall_cycles, 15);

      // Randomized traffic with occasional asynchronous reset
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         bus.id_rs        = RW'($urandom_range(0, 3));
         bus.id_rt        = RW'($urandom_range(0, 3));
         bus.id_uses_rs   = $urandom_range(0, 1) == 1;
         bus.id_uses_rt   = $urandom_range(0, 1) == 1;
         bus.ex_valid     = $urandom_range(0, 3) != 0;
         bus.ex_mem_read  = $urandom_range(0, 1) == 1;
         bus.ex_rd        = RW'($urandom_range(0, 3));
         bus.branch_taken = $urandom_range(0, 4) == 0;
         bus.mem_req      = $urandom_range(0, 2) == 0;
         bus.mem_ready    = $urandom_range(0, 1) == 1;
         rst              = $urandom_range(0, 39) != 0;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
